// File: rtl/spmv_mem_rsp.sv
// Memory-side responder: buffers spmv_pe load/store requests, issues them in order to one MC port,
// returns tagged load data through a credit-protected FIFO. Define SPMV_MEM_RSP_CHECK_EN for the sticky err flag.
module spmv_mem_rsp #(
  parameter int RSP_DEPTH  = 16,
  parameter int TAG_WIDTH  = 3,
  parameter int ADDR_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_mem_ld,
  input  logic                  req_mem_st,
  input  logic [ADDR_WIDTH-1:0] req_mem_addr,
  input  logic [63:0]           req_mem_d_or_tag,
  output logic                  req_mem_stall,
  output logic                  rsp_mem_push,
  output logic [TAG_WIDTH-1:0]  rsp_mem_tag,
  output logic [63:0]           rsp_mem_q,
  input  logic                  rsp_mem_stall,
  output logic                  mc_req_ld,
  output logic                  mc_req_st,
  output logic [ADDR_WIDTH-1:0] mc_req_vaddr,
  output logic [63:0]           mc_req_wrd_rdctl,
  input  logic                  mc_rd_rq_stall,
  input  logic                  mc_wr_rq_stall,
  input  logic                  mc_rsp_push,
  input  logic [31:0]           mc_rsp_rdctl,
  input  logic [63:0]           mc_rsp_data,
  output logic                  mc_rsp_stall,
  output logic                  idle,
  output logic                  err
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

  logic                  rq_ld_q   [2];
  logic [ADDR_WIDTH-1:0] rq_addr_q [2];
  logic [63:0]           rq_dat_q  [2];
  logic                  rq_wp_q, rq_rp_q;
  logic [1:0]            rq_cnt_q, rq_cnt_d;

  logic [TAG_WIDTH-1:0]  rf_tag_q [RSP_DEPTH];
  logic [63:0]           rf_dat_q [RSP_DEPTH];
  logic [PW-1:0]         rf_wp_q, rf_rp_q;
  logic [CW-1:0]         rf_cnt_q, rf_cnt_d;

  logic [CW-1:0]         cred_q, cred_d;
  logic                  rsp_push_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [63:0]           rsp_dat_q;

  logic req_any, req_both, req_acc, ld_acc;
  logic head_valid, head_ld, issue;
  logic rf_full, rf_wr, rf_pop;
  logic unused_rdctl_hi;

  assign req_any  = req_mem_ld | req_mem_st;
  assign req_both = req_mem_ld & req_mem_st;
  // Requests made while stalled, or with ld and st together, are dropped rather than buffered.
  assign req_acc  = req_any & ~req_both & ~req_mem_stall;
  assign ld_acc   = req_acc & req_mem_ld;

  assign req_mem_stall = (rq_cnt_q == 2'd2) | (cred_q == FULL_CNT);

  assign head_valid = (rq_cnt_q != 2'd0);
  assign head_ld    = rq_ld_q[rq_rp_q];
  assign mc_req_ld  = head_valid & head_ld & ~mc_rd_rq_stall;
  assign mc_req_st  = head_valid & ~head_ld & ~mc_wr_rq_stall;
  assign issue      = mc_req_ld | mc_req_st;

  assign mc_req_vaddr     = rq_addr_q[rq_rp_q];
  assign mc_req_wrd_rdctl = head_ld ? {{(64-TAG_WIDTH){1'b0}}, rq_dat_q[rq_rp_q][TAG_WIDTH-1:0]}
                                    : rq_dat_q[rq_rp_q];

  // A response with no credit outstanding can only be stale traffic from before a reset.
  assign rf_full = (rf_cnt_q == FULL_CNT);
  assign rf_wr   = mc_rsp_push & ~rf_full & (cred_q != '0);
  assign rf_pop  = (rf_cnt_q != '0) & ~rsp_mem_stall;

  assign rq_cnt_d = rq_cnt_q + 2'(req_acc) - 2'(issue);
  assign rf_cnt_d = rf_cnt_q + CW'(rf_wr) - CW'(rf_pop);
  assign cred_d   = cred_q + CW'(ld_acc) - CW'(rf_pop);

  assign mc_rsp_stall    = rf_full;
  assign idle            = (rq_cnt_q == 2'd0) & (cred_q == '0);
  assign rsp_mem_push    = rsp_push_q;
  assign rsp_mem_tag     = rsp_tag_q;
  assign rsp_mem_q       = rsp_dat_q;
  assign unused_rdctl_hi = ^mc_rsp_rdctl[31:TAG_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wp_q    <= 1'b0;
      rq_rp_q    <= 1'b0;
      rq_cnt_q   <= 2'd0;
      rf_wp_q    <= '0;
      rf_rp_q    <= '0;
      rf_cnt_q   <= '0;
      cred_q     <= '0;
      rsp_push_q <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_dat_q  <= '0;
    end else begin
      if (req_acc) rq_wp_q <= ~rq_wp_q;
      if (issue)   rq_rp_q <= ~rq_rp_q;
      if (rf_wr)   rf_wp_q <= rf_wp_q + PW'(1);
      if (rf_pop)  rf_rp_q <= rf_rp_q + PW'(1);
      rq_cnt_q   <= rq_cnt_d;
      rf_cnt_q   <= rf_cnt_d;
      cred_q     <= cred_d;
      rsp_push_q <= rf_pop;
      if (rf_pop) begin
        rsp_tag_q <= rf_tag_q[rf_rp_q];
        rsp_dat_q <= rf_dat_q[rf_rp_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) begin
      rq_ld_q[rq_wp_q]   <= req_mem_ld;
      rq_addr_q[rq_wp_q] <= req_mem_addr;
      rq_dat_q[rq_wp_q]  <= req_mem_d_or_tag;
    end
    if (rf_wr) begin
      rf_tag_q[rf_wp_q] <= mc_rsp_rdctl[TAG_WIDTH-1:0];
      rf_dat_q[rf_wp_q] <= mc_rsp_data;
    end
  end

`ifdef SPMV_MEM_RSP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((req_any & (req_mem_stall | req_both)) | (mc_rsp_push & ~rf_wr)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
